// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core: datapath widths, forward-select
// encodings and the layout of the ID/EX control word.
package core_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int CTLW = 10;

    // Operand source chosen by the EX stage for each register operand.
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    // Control portion of the ID/EX register; a bubble is this struct all zero.
    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic [RAW-1:0]  rd;
        logic [CTLW-1:0] ctl;
    } id_ex_ctl_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard logic for the ID stage: same-cycle writeback bypass,
// load-use detection and the forward selects that EX will use next cycle.
module hazard_fwd_unit
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int RAW  = core_pkg::RAW
) (
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] rf_dataA,
    input  logic [XLEN-1:0] rf_dataB,
    input  logic            wb_regwrite,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_regwrite,
    input  logic [RAW-1:0]  mem_rd,
    input  logic            ex_valid,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic [RAW-1:0]  ex_rd,
    output logic [XLEN-1:0] opA,
    output logic [XLEN-1:0] opB,
    output logic            lu,
    output fwd_sel_e        fwdA,
    output fwd_sel_e        fwdB
);

    logic wb_hit_a, wb_hit_b;
    logic ex_wr, ex_hit_a, ex_hit_b;
    logic mem_wr, mem_hit_a, mem_hit_b;

    // The register file writes on the edge, so a same-cycle read is stale;
    // x0 is hardwired and never bypassed.
    assign wb_hit_a = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1);
    assign wb_hit_b = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2);
    assign opA      = wb_hit_a ? wb_data : rf_dataA;
    assign opB      = wb_hit_b ? wb_data : rf_dataB;

    // The instruction now in EX will sit in MEM when this one reaches EX.
    assign ex_wr     = ex_valid && ex_regwrite && (ex_rd != '0);
    assign ex_hit_a  = ex_wr && (ex_rd == id_rs1);
    assign ex_hit_b  = ex_wr && (ex_rd == id_rs2);
    assign mem_wr    = mem_regwrite && (mem_rd != '0);
    assign mem_hit_a = mem_wr && (mem_rd == id_rs1);
    assign mem_hit_b = mem_wr && (mem_rd == id_rs2);

    // Load data is not ready for EX next cycle, so a consumer must wait one.
    assign lu = id_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Youngest producer wins: the EX-stage match beats the MEM-stage match.
    always_comb begin
        // NOTE: default first so every path assigns the outputs and no latch is inferred.
        fwdA = FWD_NONE;
        fwdB = FWD_NONE;
        if (ex_hit_a)       fwdA = FWD_MEM;
        else if (mem_hit_a) fwdA = FWD_WB;
        if (ex_hit_b)       fwdB = FWD_MEM;
        else if (mem_hit_b) fwdB = FWD_WB;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded control, immediate and bypassed
// operands, inserts bubbles on load-use or flush, and counts those bubbles.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int RAW  = core_pkg::RAW,
    parameter int CTLW = core_pkg::CTLW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [RAW-1:0]  id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic [CTLW-1:0] id_ctl,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] rf_dataA,
    input  logic [XLEN-1:0] rf_dataB,
    input  logic            wb_regwrite,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_regwrite,
    input  logic [RAW-1:0]  mem_rd,
    input  logic            flush,
    input  logic            hold,
    output logic            stall_id,
    output logic            ex_valid,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_opA,
    output logic [XLEN-1:0] ex_opB,
    output logic [RAW-1:0]  ex_rd,
    output logic [CTLW-1:0] ex_ctl,
    output logic [1:0]      ex_fwdA,
    output logic [1:0]      ex_fwdB,
    output logic [15:0]     bubble_cnt
);

    logic [XLEN-1:0] op_a, op_b;
    logic            lu;
    fwd_sel_e        fwd_a, fwd_b;
    fwd_sel_e        fwd_a_q, fwd_b_q;
    logic            update, take_bubble, count_bubble;

    hazard_fwd_unit #(.XLEN(XLEN), .RAW(RAW)) u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .rf_dataA    (rf_dataA),
        .rf_dataB    (rf_dataB),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mem_regwrite(mem_regwrite),
        .mem_rd      (mem_rd),
        .ex_valid    (ex_valid),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .opA         (op_a),
        .opB         (op_b),
        .lu          (lu),
        .fwdA        (fwd_a),
        .fwdB        (fwd_b)
    );

    // A flush kills the stalled instruction anyway, so it never also stalls.
    assign stall_id = lu && !flush;

    // Flush overrides hold; otherwise hold freezes everything, including the count.
    assign update       = flush || !hold;
    assign take_bubble  = flush || lu || !id_valid;
    assign count_bubble = flush || (!hold && lu);

    assign ex_fwdA = fwd_a_q;
    assign ex_fwdB = fwd_b_q;

    // ID/EX register and saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_opA      <= '0;
            ex_opB      <= '0;
            ex_rd       <= '0;
            ex_ctl      <= '0;
            fwd_a_q     <= FWD_NONE;
            fwd_b_q     <= FWD_NONE;
            bubble_cnt  <= '0;
        end else if (update) begin
            if (take_bubble) begin
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_pc       <= '0;
                ex_imm      <= '0;
                ex_opA      <= '0;
                ex_opB      <= '0;
                ex_rd       <= '0;
                ex_ctl      <= '0;
                fwd_a_q     <= FWD_NONE;
                fwd_b_q     <= FWD_NONE;
            end else begin
                ex_valid    <= 1'b1;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                ex_pc       <= id_pc;
                ex_imm      <= id_imm;
                ex_opA      <= op_a;
                ex_opB      <= op_b;
                ex_rd       <= id_rd;
                ex_ctl      <= id_ctl;
                fwd_a_q     <= fwd_a;
                fwd_b_q     <= fwd_b;
            end
            if (count_bubble && (bubble_cnt != 16'hFFFF))
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic        id_regwrite, id_memread;
    logic [9:0]  id_ctl;
    logic [31:0] id_imm;
    logic [31:0] rf_dataA, rf_dataB;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic        flush, hold;
    logic        stall_id;
    logic        ex_valid, ex_regwrite, ex_memread;
    logic [31:0] ex_pc, ex_imm, ex_opA, ex_opB;
    logic [4:0]  ex_rd;
    logic [9:0]  ex_ctl;
    logic [1:0]  ex_fwdA, ex_fwdB;
    logic [15:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_ctl(id_ctl), .id_imm(id_imm),
        .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .flush(flush), .hold(hold),
        .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_opA(ex_opA), .ex_opB(ex_opB),
        .ex_rd(ex_rd), .ex_ctl(ex_ctl),
        .ex_fwdA(ex_fwdA), .ex_fwdB(ex_fwdB),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_memread = 0;
        id_ctl = 0; id_imm = 0; rf_dataA = 0; rf_dataB = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0;
        mem_regwrite = 0; mem_rd = 0; flush = 0; hold = 0;
    endtask

    // Put a valid instruction in ID that reads x1/x2 and writes rd.
    task automatic issue(input logic [4:0] rd, input logic memread);
        id_valid = 1; id_rd = rd; id_regwrite = 1; id_memread = memread;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1; id_use_rs2 = 1;
        id_pc = 32'h200; id_imm = 0; id_ctl = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ex_valid); end
        total++; if (ex_opA !== 32'h0) begin bad++; $display("FAIL reset_opA got=%h want=0", ex_opA); end
        total++; if (ex_fwdA !== 2'b00 || ex_fwdB !== 2'b00) begin bad++; $display("FAIL reset_fwd got=%b/%b want=00/00", ex_fwdA, ex_fwdB); end
        total++; if (bubble_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", bubble_cnt); end
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_id); end
        rst_n = 1;
        step();
    endtask

    task automatic test_wb_bypass();
        id_valid = 1; id_pc = 32'h100; id_rs1 = 5; id_rs2 = 6; id_rd = 9;
        id_use_rs1 = 1; id_use_rs2 = 1; id_regwrite = 1; id_ctl = 10'h155; id_imm = 32'h44;
        rf_dataA = 32'h1; rf_dataB = 32'h2;
        wb_regwrite = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        step();
        total++; if (ex_opA !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_bypass_opA got=%h want=deadbeef", ex_opA); end
        total++; if (ex_opB !== 32'h2) begin bad++; $display("FAIL wb_nobypass_opB got=%h want=2", ex_opB); end
        total++; if (ex_valid !== 1 || ex_regwrite !== 1 || ex_rd !== 5'd9) begin bad++; $display("FAIL wb_ctl got=v%b w%b rd%0d want=v1 w1 rd9", ex_valid, ex_regwrite, ex_rd); end
        total++; if (ex_pc !== 32'h100 || ex_imm !== 32'h44 || ex_ctl !== 10'h155) begin bad++; $display("FAIL wb_fields got=%h %h %h want=100 44 155", ex_pc, ex_imm, ex_ctl); end
        // x0 is never bypassed
        wb_rd = 0; id_rs1 = 0; id_rs2 = 0;
        step();
        total++; if (ex_opA !== 32'h1) begin bad++; $display("FAIL wb_x0_opA got=%h want=1", ex_opA); end
        // rs2 bypass
        wb_rd = 6; id_rs2 = 6; id_rs1 = 4;
        step();
        total++; if (ex_opB !== 32'hDEADBEEF || ex_opA !== 32'h1) begin bad++; $display("FAIL wb_bypass_opB got=%h/%h want=1/deadbeef", ex_opA, ex_opB); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        issue(5'd7, 1'b1);
        step();
        id_rs1 = 3; id_rs2 = 7; id_rd = 8; id_memread = 0;
        #1;
        total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", stall_id); end
        step();
        total++; if (ex_valid !== 0 || ex_rd !== 0 || ex_ctl !== 0) begin bad++; $display("FAIL lu_bubble got=v%b rd%0d want=v0 rd0", ex_valid, ex_rd); end
        total++; if (bubble_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", bubble_cnt); end
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL lu_stall_clear got=%b want=0", stall_id); end
        mem_regwrite = 1; mem_rd = 7;
        step();
        total++; if (ex_valid !== 1 || ex_rd !== 5'd8 || ex_fwdB !== 2'b10 || ex_fwdA !== 2'b00) begin bad++; $display("FAIL lu_resume got=v%b rd%0d fwd%b/%b want=v1 rd8 fwd00/10", ex_valid, ex_rd, ex_fwdA, ex_fwdB); end
        total++; if (bubble_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt_once got=%0d want=1", bubble_cnt); end
        idle_inputs();
    endtask

    task automatic test_false_dep();
        issue(5'd7, 1'b1);
        step();
        id_rs1 = 3; id_rs2 = 7; id_rd = 8; id_memread = 0; id_use_rs2 = 0;
        #1;
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL fdep_stall got=%b want=0", stall_id); end
        step();
        total++; if (ex_valid !== 1 || ex_rd !== 5'd8 || bubble_cnt !== 16'd1) begin bad++; $display("FAIL fdep_load got=v%b rd%0d cnt%0d want=v1 rd8 cnt1", ex_valid, ex_rd, bubble_cnt); end
        total++; if (ex_fwdB !== 2'b01) begin bad++; $display("FAIL fdep_fwdB got=%b want=01", ex_fwdB); end
        idle_inputs();
    endtask

    task automatic test_fwd_priority();
        issue(5'd3, 1'b0);
        step();
        mem_regwrite = 1; mem_rd = 3;
        id_valid = 1; id_rs1 = 3; id_rs2 = 4; id_rd = 10; id_use_rs1 = 1; id_use_rs2 = 1; id_regwrite = 1;
        step();
        total++; if (ex_fwdA !== 2'b01 || ex_fwdB !== 2'b00) begin bad++; $display("FAIL fwd_prio got=%b/%b want=01/00", ex_fwdA, ex_fwdB); end
        // EX now writes x10, MEM writes x3
        step();
        total++; if (ex_fwdA !== 2'b10) begin bad++; $display("FAIL fwd_mem_only got=%b want=10", ex_fwdA); end
        // x0 never forwarded
        mem_rd = 0; id_rs1 = 0; id_rd = 0;
        step();
        total++; if (ex_fwdA !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b want=00", ex_fwdA); end
        idle_inputs();
    endtask

    task automatic test_flush_lu();
        issue(5'd7, 1'b1);
        step();
        id_rs2 = 7; id_rd = 8; id_memread = 0; flush = 1;
        #1;
        total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL flush_lu_stall got=%b want=0", stall_id); end
        step();
        total++; if (ex_valid !== 0 || bubble_cnt !== 16'd2) begin bad++; $display("FAIL flush_lu got=v%b cnt%0d want=v0 cnt2", ex_valid, bubble_cnt); end
        flush = 0;
        issue(5'd7, 1'b1);
        step();
        id_rs2 = 7; id_rd = 8; id_memread = 0; flush = 1; hold = 1;
        step();
        total++; if (ex_valid !== 0 || ex_rd !== 0 || bubble_cnt !== 16'd3) begin bad++; $display("FAIL flush_hold got=v%b rd%0d cnt%0d want=v0 rd0 cnt3", ex_valid, ex_rd, bubble_cnt); end
        idle_inputs();
    endtask

    task automatic test_hold_lu();
        issue(5'd7, 1'b1);
        step();
        id_rs2 = 7; id_rd = 8; id_memread = 0; hold = 1;
        step();
        total++; if (ex_valid !== 1 || ex_rd !== 5'd7 || ex_memread !== 1) begin bad++; $display("FAIL hold_frozen got=v%b rd%0d m%b want=v1 rd7 m1", ex_valid, ex_rd, ex_memread); end
        total++; if (stall_id !== 1'b1 || bubble_cnt !== 16'd3) begin bad++; $display("FAIL hold_stall got=s%b cnt%0d want=s1 cnt3", stall_id, bubble_cnt); end
        // invalid ID instruction loads as an uncounted bubble
        hold = 0; id_valid = 0;
        step();
        total++; if (ex_valid !== 0 || ex_regwrite !== 0 || ex_rd !== 0 || bubble_cnt !== 16'd3) begin bad++; $display("FAIL invalid_id got=v%b w%b rd%0d cnt%0d want=v0 w0 rd0 cnt3", ex_valid, ex_regwrite, ex_rd, bubble_cnt); end
        idle_inputs();
    endtask

    task automatic test_saturation();
        flush = 1;
        for (int i = 0; i < 65537; i++) step();
        total++; if (bubble_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%h want=ffff", bubble_cnt); end
        flush = 0;
        issue(5'd9, 1'b0);
        step();
        total++; if (bubble_cnt !== 16'hFFFF || ex_valid !== 1) begin bad++; $display("FAIL sat_hold got=%h v%b want=ffff v1", bubble_cnt, ex_valid); end
        #2;
        rst_n = 0;
        #1;
        total++; if (ex_valid !== 0 || ex_pc !== 0 || ex_rd !== 0 || ex_regwrite !== 0 || bubble_cnt !== 0) begin bad++; $display("FAIL async_reset got=v%b pc%h rd%0d cnt%h want=all 0", ex_valid, ex_pc, ex_rd, bubble_cnt); end
        rst_n = 1;
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
        test_load_use();
        test_false_dep();
        test_fwd_priority();
        test_flush_lu();
        test_hold_lu();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
